// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//   Single-port instruction memory acting as the slave end of instr_bus
//   (req/gnt/rvalid/rdata). It inserts WAIT_STATES idle cycles before gnt,
//   returns rdata one cycle after gnt, and has a side load port for writing
//   the code image.
//
//   The instr_bus slave signals appear as flat ports ibus_<signal>.
//
//   Optional feature macro: INSTR_MEM_PERF_CNT_EN
//     Adds perf_fetch_cnt (+1 per gnt) and perf_stall_cnt (+1 per cycle with
//     req=1 and gnt=0). When undefined, both ports and counters are absent.
//
//   DEPTH_WORDS must be a power of two. WAIT_STATES ranges over 0..15.
module instr_mem_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ibus_req,
    input  logic [31:0] ibus_addr,
    output logic        ibus_gnt,
    output logic        ibus_rvalid,
    output logic [31:0] ibus_rdata,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata
`ifdef INSTR_MEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
    // Counter load value: number of WAIT-state cycles still to spend before GRANT
    // once IDLE has seen req. IDLE plus the WAIT cycles plus GRANT add up to
    // WAIT_STATES+1 cycles per fetch.
    localparam logic [3:0]  WS_M1   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GRANT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Address decode: idx = (addr - BASE) >> 2, in range iff idx < DEPTH.
    // The subtraction wraps, so addresses below BASE land far out of range.
    // ------------------------------------------------------------------
    logic [31:0]   rd_off, ld_off;
    logic [29:0]   rd_word, ld_word;
    logic          rd_in_range, ld_in_range;
    logic [AW-1:0] rd_idx, ld_idx;
    logic [1:0]    unused_lsb;

    assign rd_off      = ibus_addr - BASE_ADDRESS;
    assign ld_off      = load_addr - BASE_ADDRESS;
    assign rd_word     = rd_off[31:2];
    assign ld_word     = ld_off[31:2];
    assign rd_in_range = ({2'b00, rd_word} < DEPTH_U);
    assign ld_in_range = ({2'b00, ld_word} < DEPTH_U);
    assign rd_idx      = rd_word[AW-1:0];
    assign ld_idx      = ld_word[AW-1:0];
    // Byte-lane bits carry no meaning for a word-wide memory.
    assign unused_lsb  = rd_off[1:0] ^ ld_off[1:0];

    // Next-state and grant decode. gnt is combinational from req so that a
    // zero-wait memory can accept a fetch in the cycle it is requested; it is
    // forced low while reset is held so no fetch slips through reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ibus_req) begin
                    if (WAIT_STATES == 0) begin
                        gnt = 1'b1;
                    end else begin
                        cnt_d   = WS_M1;
                        state_d = (WS_M1 == 4'd0) ? S_GRANT : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!ibus_req) begin
                    // Requester withdrew: abandon the fetch silently.
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = S_GRANT;
                    end
                end
            end
            S_GRANT: begin
                gnt     = ibus_req;
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (!rst_n) begin
            gnt = 1'b0;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read response: one-cycle rvalid pulse after each gnt; rdata is captured
    // only on gnt and holds otherwise. Out-of-range fetches return zero.
    // The memory write below is non-blocking, so a same-cycle load to the
    // fetched word is seen only by later fetches (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            rvalid_q <= gnt;
            if (gnt) begin
                rdata_q <= rd_in_range ? mem[rd_idx] : 32'h0000_0000;
            end
        end
    end

    // Load port write; out-of-range writes are dropped. Memory is not reset,
    // so a loader may fill it while the core is still held in reset.
    always_ff @(posedge clk) begin
        if (load_we && ld_in_range) begin
            mem[ld_idx] <= load_wdata;
        end
    end

    assign ibus_gnt    = gnt;
    assign ibus_rvalid = rvalid_q;
    assign ibus_rdata  = rdata_q;

`ifdef INSTR_MEM_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Performance counters: fetches accepted and cycles spent waiting for gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (gnt) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ibus_req && !gnt) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder
//   Four instances share one clock and reset; instance k has WAIT_STATES=k.
//   Instance 0 uses BASE_ADDRESS 0x1000, the others 0. Instance 1 exists only
//   when INSTR_MEM_PERF_CNT_EN is defined. Stimulus pushes expected read data
//   into a queue; a monitor pops and compares on every rvalid.
module tb_instr_mem_responder;

`ifdef INSTR_MEM_PERF_CNT_EN
    localparam bit HAS_PERF = 1'b1;
`else
    localparam bit HAS_PERF = 1'b0;
`endif

    typedef struct {
        int          inst;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req    [4];
    logic [31:0] addr   [4];
    logic        gnt    [4];
    logic        rvalid [4];
    logic [31:0] rdata  [4];
    logic        we     [4];
    logic [31:0] laddr  [4];
    logic [31:0] lwdata [4];
`ifdef INSTR_MEM_PERF_CNT_EN
    logic [31:0] pf_fetch [4];
    logic [31:0] pf_stall [4];
`endif

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        if (g != 1 || HAS_PERF) begin : g_on
            instr_mem_responder #(
                .BASE_ADDRESS ((g == 0) ? 32'h0000_1000 : 32'h0000_0000),
                .DEPTH_WORDS  (16),
                .WAIT_STATES  (g)
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .ibus_req    (req[g]),
                .ibus_addr   (addr[g]),
                .ibus_gnt    (gnt[g]),
                .ibus_rvalid (rvalid[g]),
                .ibus_rdata  (rdata[g]),
                .load_we     (we[g]),
                .load_addr   (laddr[g]),
                .load_wdata  (lwdata[g])
`ifdef INSTR_MEM_PERF_CNT_EN
                ,
                .perf_fetch_cnt (pf_fetch[g]),
                .perf_stall_cnt (pf_stall[g])
`endif
            );
        end else begin : g_off
            assign gnt[g]    = 1'b0;
            assign rvalid[g] = 1'b0;
            assign rdata[g]  = 32'h0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
        we[k] = 1'b1; laddr[k] = a; lwdata[k] = d;
        cyc();
        we[k] = 1'b0;
    endtask

    // One bus cycle on instance k: drive req/addr, check gnt and rvalid at the
    // falling edge, and queue the expected read data when a gnt is expected.
    task automatic fcyc(input int k, input logic r, input logic [31:0] a,
                        input logic eg, input logic [31:0] ed, input logic erv,
                        input string nm);
        exp_t t;
        req[k]  = r;
        addr[k] = a;
        @(negedge clk);
        chk({nm, ".gnt"},    32'(gnt[k]),    32'(eg));
        chk({nm, ".rvalid"}, 32'(rvalid[k]), 32'(erv));
        if (eg) begin
            t.inst = k;
            t.data = ed;
            sb_q.push_back(t);
        end
        cyc();
    endtask

    // Monitor: every rvalid must match the oldest expected response.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (rvalid[k] === 1'b1) begin
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rdata_unexpected inst%0d: got %h expected no rvalid", k, rdata[k]);
                end else begin
                    e = sb_q.pop_front();
                    if (e.inst != k || rdata[k] !== e.data) begin
                        n_fail++;
                        $display("FAIL rdata inst%0d: got %h expected inst%0d data %h",
                                 k, rdata[k], e.inst, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no end of test expected end within 50000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req[k] = 1'b0; addr[k] = 32'h0; we[k] = 1'b0; laddr[k] = 32'h0; lwdata[k] = 32'h0;
        end
        // Request held through reset on the zero-wait instance.
        req[0]  = 1'b1;
        addr[0] = 32'h0000_1000;
        cyc();

        // Code images loaded while reset is held.
        load(0, 32'h0000_1000, 32'h11);
        load(0, 32'h0000_1004, 32'h22);
        load(0, 32'h0000_1008, 32'h33);
        load(0, 32'h0000_100C, 32'h44);
        load(0, 32'h0000_103C, 32'hF00D);
        load(2, 32'h0000_0004, 32'h22);
        load(2, 32'h0000_0008, 32'h88);
        load(3, 32'h0000_0008, 32'h55);
`ifdef INSTR_MEM_PERF_CNT_EN
        for (int i = 0; i < 5; i++) load(1, 32'(4 * i), 32'h100 + 32'(i));
`endif

        @(negedge clk);
        chk("reset.gnt",    32'(gnt[0]),    32'h0);
        chk("reset.rvalid", 32'(rvalid[0]), 32'h0);
        chk("reset.rdata",  rdata[0],       32'h0);
        chk("reset.ws2_gnt", 32'(gnt[2]),   32'h0);
        cyc();
        rst_n = 1'b1;

        // Zero wait states: streaming, range edges, lsb ignore, collision.
        fcyc(0, 1, 32'h0000_1000, 1, 32'h11,   0, "s0.first");
        fcyc(0, 1, 32'h0000_1004, 1, 32'h22,   1, "s0.w1");
        fcyc(0, 1, 32'h0000_1008, 1, 32'h33,   1, "s0.w2");
        fcyc(0, 1, 32'h0000_100C, 1, 32'h44,   1, "s0.w3");
        fcyc(0, 1, 32'h0000_1040, 1, 32'h0,    1, "s0.above");
        fcyc(0, 1, 32'h0000_0FFC, 1, 32'h0,    1, "s0.below");
        fcyc(0, 1, 32'h0000_103C, 1, 32'hF00D, 1, "s0.last");
        fcyc(0, 1, 32'h0000_1005, 1, 32'h22,   1, "s0.lsb");
        we[0] = 1'b1; laddr[0] = 32'h0000_1004; lwdata[0] = 32'hAB;
        fcyc(0, 1, 32'h0000_1004, 1, 32'h22,   1, "s0.collide");
        we[0] = 1'b0;
        fcyc(0, 1, 32'h0000_1004, 1, 32'hAB,   1, "s0.after");
        we[0] = 1'b1; laddr[0] = 32'h0000_1040; lwdata[0] = 32'hDEAD;
        fcyc(0, 0, 32'h0000_1000, 0, 32'h0,    1, "s0.oorload");
        we[0] = 1'b0;
        fcyc(0, 1, 32'h0000_1000, 1, 32'h11,   0, "s0.w0again");
        fcyc(0, 0, 32'h0000_1000, 0, 32'h0,    1, "s0.idle");
        @(negedge clk);
        chk("s0.pulse",   32'(rvalid[0]), 32'h0);
        chk("s0.holdrd",  rdata[0],       32'h11);
        cyc();

        // Two wait states; address changes during WAIT must be ignored.
        fcyc(2, 1, 32'h0000_0040, 0, 32'h0,  0, "w2.c1");
        fcyc(2, 1, 32'h0000_0040, 0, 32'h0,  0, "w2.c2");
        fcyc(2, 1, 32'h0000_0004, 1, 32'h22, 0, "w2.c3");
        fcyc(2, 1, 32'h0000_0008, 0, 32'h0,  1, "w2.c4");
        fcyc(2, 1, 32'h0000_0008, 0, 32'h0,  0, "w2.c5");
        fcyc(2, 1, 32'h0000_0008, 1, 32'h88, 0, "w2.c6");
        fcyc(2, 0, 32'h0000_0000, 0, 32'h0,  1, "w2.c7");
        fcyc(2, 0, 32'h0000_0000, 0, 32'h0,  0, "w2.c8");

        // Three wait states: abort after two cycles, then a full request.
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "ab.a1");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "ab.a2");
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0,  0, "ab.a3");
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0,  0, "ab.a4");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "ab.b1");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "ab.b2");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "ab.b3");
        fcyc(3, 1, 32'h0000_0008, 1, 32'h55, 0, "ab.b4");
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0,  1, "ab.b5");
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0,  0, "ab.b6");

`ifdef INSTR_MEM_PERF_CNT_EN
        // One wait state, five back-to-back fetches with req held.
        for (int i = 0; i < 5; i++) begin
            fcyc(1, 1, 32'(4 * i), 0, 32'h0,              (i > 0), "pf.wait");
            fcyc(1, 1, 32'(4 * i), 1, 32'h100 + 32'(i),   0,       "pf.gnt");
        end
        fcyc(1, 0, 32'h0, 0, 32'h0, 1, "pf.end");
        @(negedge clk);
        chk("pf.fetch_cnt", pf_fetch[1], 32'd5);
        chk("pf.stall_cnt", pf_stall[1], 32'd5);
        cyc();
`endif

        // Reset while instance 3 sits in GRANT: the fetch must vanish.
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0, 0, "mr.c1");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0, 0, "mr.c2");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0, 0, "mr.c3");
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr.gnt_in_reset",    32'(gnt[3]),    32'h0);
        chk("mr.rvalid_in_reset", 32'(rvalid[3]), 32'h0);
        cyc();
        req[3] = 1'b0;
        rst_n  = 1'b1;
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0, 0, "mr.q1");
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0, 0, "mr.q2");
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0, 0, "mr.q3");
`ifdef INSTR_MEM_PERF_CNT_EN
        @(negedge clk);
        chk("mr.perf_fetch_reset", pf_fetch[1], 32'd0);
        chk("mr.perf_stall_reset", pf_stall[1], 32'd0);
        cyc();
`endif
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "mr.r1");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "mr.r2");
        fcyc(3, 1, 32'h0000_0008, 0, 32'h0,  0, "mr.r3");
        fcyc(3, 1, 32'h0000_0008, 1, 32'h55, 0, "mr.r4");
        fcyc(3, 0, 32'h0000_0008, 0, 32'h0,  1, "mr.r5");

        cyc();
        cyc();
        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
